// File: rtl/crumb_cmp_pkg.sv
// Shared types and result encodings for the registered crumb (2-bit) comparator.
// Result bit order is {f1,f2,f3} = {greater, equal, less}.
package crumb_cmp_pkg;

  typedef logic [1:0] crumb_t;
  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_GT   = 3'b100;
  localparam cmp_res_t CMP_EQ   = 3'b010;
  localparam cmp_res_t CMP_LT   = 3'b001;
  localparam cmp_res_t CMP_NONE = 3'b000;

endpackage : crumb_cmp_pkg

// File: rtl/crumb_cmp_comb.sv
// Purely combinational unsigned crumb compare; emits exactly one of GT/EQ/LT.
module crumb_cmp_comb
  import crumb_cmp_pkg::*;
(
  input  crumb_t   a,
  input  crumb_t   b,
  output cmp_res_t res
);

  always_comb begin
    res = CMP_EQ;
    if (a > b) begin
      res = CMP_GT;
    end else if (a < b) begin
      res = CMP_LT;
    end
  end

endmodule : crumb_cmp_comb

// File: rtl/crumb_comparator_sync.sv
// Registered 2-bit magnitude comparator: f1 = A>B, f2 = A==B, f3 = A<B, outputs straight from flops.
// Build option CRUMB_CMP_INREG_EN adds an operand register stage (latency 2 instead of 1).
module crumb_comparator_sync
  import crumb_cmp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a1,
  input  logic a2,
  input  logic b1,
  input  logic b2,
  output logic f1,
  output logic f2,
  output logic f3
);

  crumb_t   op_a;
  crumb_t   op_b;
  cmp_res_t cmp_res;
  cmp_res_t res_d;
  cmp_res_t res_q;

`ifdef CRUMB_CMP_INREG_EN
  crumb_t a_d;
  crumb_t a_q;
  crumb_t b_d;
  crumb_t b_q;
  logic   vld_d;
  logic   vld_q;

  always_comb begin
    a_d   = {a2, a1};
    b_d   = {b2, b1};
    vld_d = 1'b1;
  end

  // Input stage: vld_q marks that a_q/b_q hold a real post-reset sample,
  // so the reset value 0/0 is never reported as "equal".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
    end
  end

  always_comb begin
    op_a = a_q;
    op_b = b_q;
  end
`else
  always_comb begin
    op_a = {a2, a1};
    op_b = {b2, b1};
  end
`endif

  crumb_cmp_comb u_cmp (
    .a   (op_a),
    .b   (op_b),
    .res (cmp_res)
  );

  always_comb begin
    res_d = cmp_res;
`ifdef CRUMB_CMP_INREG_EN
    if (!vld_q) begin
      res_d = CMP_NONE;
    end
`endif
  end

  // Output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= CMP_NONE;
    end else begin
      res_q <= res_d;
    end
  end

  assign {f1, f2, f3} = res_q;

endmodule : crumb_comparator_sync

// File: tb/tb_crumb_comparator_sync.sv
// Self-checking bench for crumb_comparator_sync (honours CRUMB_CMP_INREG_EN for expected latency).
module tb_crumb_comparator_sync;

`ifdef CRUMB_CMP_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a1 = 1'b0, a2 = 1'b0, b1 = 1'b0, b2 = 1'b0;
  logic f1, f2, f3;

  crumb_comparator_sync dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a1    (a1),
    .a2    (a2),
    .b1    (b1),
    .b2    (b2),
    .f1    (f1),
    .f2    (f2),
    .f3    (f3)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: count of consecutive non-reset edges plus the previous edge's operands.
  int         run = 0;
  logic [1:0] prev_a = 2'd0, prev_b = 2'd0;
  logic [2:0] model_out = 3'b000;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [2:0] rank(int a, int b);
    return {a > b, a == b, a < b};
  endfunction

  task automatic chk(input string nm, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, got, exp, $time);
    end
  endtask

  // Apply one compare (or reset) for one rising edge, then check against the model.
  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic rst, input string nm);
    @(negedge clk);
    {a2, a1} = a;
    {b2, b1} = b;
    rst_n    = ~rst;
    @(posedge clk);
    if (rst) begin
      run       = 0;
      model_out = 3'b000;
    end else begin
      run++;
      if (run >= LAT) model_out = (LAT == 1) ? rank(a, b) : rank(prev_a, prev_b);
      else            model_out = 3'b000;
    end
    prev_a = a;
    prev_b = b;
    #1;
    chk(nm, {f1, f2, f3}, model_out);
  endtask

  // One-hot invariant whenever the pipeline holds a post-reset result.
  always @(negedge clk) begin
    if (run >= LAT) chk("onehot", {f1, f2, f3}, ($countones({f1, f2, f3}) == 1) ? {f1, f2, f3} : 3'bxxx);
  end

  initial begin
    logic [2:0] last;
    for (int i = 0; i < 16; i++) begin
      tbl[i].a   = i[3:2];
      tbl[i].b   = i[1:0];
      tbl[i].exp = rank(i / 4, i % 4);
    end
    // A few hand-picked anchor values
    chk("tbl_a0b0", tbl[0].exp,  3'b010);
    chk("tbl_a1b0", tbl[4].exp,  3'b100);
    chk("tbl_a1b2", tbl[6].exp,  3'b001);
    chk("tbl_a3b3", tbl[15].exp, 3'b010);

    // Reset held for 2 edges with A=3,B=0
    step(2'd3, 2'd0, 1'b1, "reset0");
    step(2'd3, 2'd0, 1'b1, "reset1");

    // Exhaustive sweep, table-driven
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].a, tbl[i].b, 1'b0, "sweep");
      if (i >= LAT - 1 && i > 0) chk("sweep_tbl", {f1, f2, f3}, tbl[i - LAT + 1].exp);
    end
    // Flush the last table entry through a 2-deep pipeline
    step(2'd0, 2'd0, 1'b0, "flush");
    if (LAT == 2) chk("sweep_tbl_last", {f1, f2, f3}, tbl[15].exp);

    // Back-to-back alternation: f1/f3 toggle, f2 stays low
    last = {f1, f2, f3};
    for (int i = 0; i < 8; i++) begin
      step((i % 2 == 0) ? 2'd2 : 2'd1, (i % 2 == 0) ? 2'd1 : 2'd2, 1'b0, "alt");
      if (i >= LAT) begin
        chk("alt_f2", {2'b00, f2}, 3'b000);
        chk("alt_toggle", {1'b0, f1, f3}, {1'b0, ~last[2], ~last[0]});
      end
      last = {f1, f2, f3};
    end

    // Mid-stream reset during a second sweep
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].a, tbl[i].b, (i == 8), (i == 8) ? "midrst" : "sweep2");
      if (i == 8) chk("midrst_zero", {f1, f2, f3}, 3'b000);
    end

    // Randomized compares with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ($urandom_range(0, 24) == 0), "rand");
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_crumb_comparator_sync
